// File: rtl/shift_pkg.sv
// Shared mode encodings and helpers for the pipelined shift unit.
package shift_pkg;

    localparam logic [1:0] SH_SLL  = 2'b00;
    localparam logic [1:0] SH_SRL  = 2'b01;
    localparam logic [1:0] SH_SRA  = 2'b10;
    localparam logic [1:0] SH_ROTR = 2'b11;

    // Widest operand the reversal helper can handle.
    localparam int SH_MAX_W = 128;

    function automatic int layers_per_stage(input int shamt_w, input int stages);
        return (shamt_w + stages - 1) / stages;
    endfunction

    // Reverses the low w bits of x; upper bits of the result are zero.
    function automatic logic [SH_MAX_W-1:0] bit_rev(input logic [SH_MAX_W-1:0] x, input int w);
        logic [SH_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SH_MAX_W; i++) begin
            if (i < w) r[w-1-i] = x[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One elastic pipeline stage: a slice of right-shift barrel layers plus its register.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SHAMT_W     = $clog2(WIDTH),
    parameter int TAG_W       = 5,
    parameter int FIRST_LAYER = 0,
    parameter int NUM_LAYERS  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [WIDTH-1:0]   in_data_i,
    input  logic [SHAMT_W-1:0] in_shamt_i,
    input  logic [1:0]         in_mode_i,
    input  logic [TAG_W-1:0]   in_tag_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [WIDTH-1:0]   out_data_o,
    output logic [SHAMT_W-1:0] out_shamt_o,
    output logic [1:0]         out_mode_o,
    output logic [TAG_W-1:0]   out_tag_o
);

    logic               valid_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         mode_q;
    logic [TAG_W-1:0]   tag_q;

    // SLL arrives bit-reversed, so it shares the zero-filling right shift with SRL.
    function automatic logic [WIDTH-1:0] shr_layer(input logic [WIDTH-1:0] x,
                                                   input logic [1:0]       mode,
                                                   input int               k);
        logic [WIDTH-1:0] fill;
        fill = '0;
        if (mode == SH_SRA && x[WIDTH-1]) begin
            fill = ~({WIDTH{1'b1}} >> k);
        end else if (mode == SH_ROTR) begin
            fill = x << (WIDTH - k);
        end
        return (x >> k) | fill;
    endfunction

    always_comb begin
        data_d = in_data_i;
        for (int l = 0; l < NUM_LAYERS; l++) begin
            if (in_shamt_i[FIRST_LAYER + l]) begin
                data_d = shr_layer(data_d, in_mode_i, 1 << (FIRST_LAYER + l));
            end
        end
    end

    assign in_ready_o = !valid_q || out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= SH_SLL;
            tag_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (in_ready_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q  <= data_d;
                shamt_q <= in_shamt_i;
                mode_q  <= in_mode_i;
                tag_q   <= in_tag_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_shamt_o = shamt_q;
    assign out_mode_o  = mode_q;
    assign out_tag_o   = tag_q;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTR) with valid/ready on both sides,
// branch-squash flush and a destination-tag passthrough.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STAGES  = 2,
    parameter int TAG_W   = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Flush,
    input  logic               InValid,
    output logic               InReady,
    input  logic [WIDTH-1:0]   InData,
    input  logic [SHAMT_W-1:0] InShamt,
    input  logic [1:0]         InMode,
    input  logic [TAG_W-1:0]   InTag,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [WIDTH-1:0]   OutData,
    output logic [TAG_W-1:0]   OutTag,
    output logic               OutZero
);

    localparam int LPS = layers_per_stage(SHAMT_W, STAGES);

    logic               vld_c   [STAGES+1];
    logic               rdy_c   [STAGES+1];
    logic [WIDTH-1:0]   data_c  [STAGES+1];
    logic [SHAMT_W-1:0] shamt_c [STAGES+1];
    logic [1:0]         mode_c  [STAGES+1];
    logic [TAG_W-1:0]   tag_c   [STAGES+1];

    logic [SH_MAX_W-1:0] rev_in_w;
    logic [SH_MAX_W-1:0] rev_out_w;
    logic                unused_rev;

    assign rev_in_w   = bit_rev(SH_MAX_W'(InData), WIDTH);
    assign vld_c[0]   = InValid;
    assign data_c[0]  = (InMode == SH_SLL) ? rev_in_w[WIDTH-1:0] : InData;
    assign shamt_c[0] = InShamt;
    assign mode_c[0]  = InMode;
    assign tag_c[0]   = InTag;

    assign rdy_c[STAGES] = OutReady;
    // Flushed and reset cycles must not swallow a request.
    assign InReady = rdy_c[0] && !Flush && !Reset;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FIRST = s * LPS;
        localparam int NUM   = (FIRST >= SHAMT_W) ? 0 :
                               ((SHAMT_W - FIRST < LPS) ? (SHAMT_W - FIRST) : LPS);
        localparam int FIRST_C = (NUM == 0) ? 0 : FIRST;

        shift_stage #(
            .WIDTH       (WIDTH),
            .SHAMT_W     (SHAMT_W),
            .TAG_W       (TAG_W),
            .FIRST_LAYER (FIRST_C),
            .NUM_LAYERS  (NUM)
        ) u_stage (
            .clk_i       (Clk),
            .rst_i       (Reset),
            .flush_i     (Flush),
            .in_valid_i  (vld_c[s]),
            .in_ready_o  (rdy_c[s]),
            .in_data_i   (data_c[s]),
            .in_shamt_i  (shamt_c[s]),
            .in_mode_i   (mode_c[s]),
            .in_tag_i    (tag_c[s]),
            .out_valid_o (vld_c[s+1]),
            .out_ready_i (rdy_c[s+1]),
            .out_data_o  (data_c[s+1]),
            .out_shamt_o (shamt_c[s+1]),
            .out_mode_o  (mode_c[s+1]),
            .out_tag_o   (tag_c[s+1])
        );
    end

    assign rev_out_w = bit_rev(SH_MAX_W'(data_c[STAGES]), WIDTH);
    assign OutValid  = vld_c[STAGES];
    assign OutData   = (mode_c[STAGES] == SH_SLL) ? rev_out_w[WIDTH-1:0] : data_c[STAGES];
    assign OutTag    = tag_c[STAGES];
    assign OutZero   = (OutData == '0);

    assign unused_rev = ^{rev_in_w[SH_MAX_W-1:WIDTH], rev_out_w[SH_MAX_W-1:WIDTH], shamt_c[STAGES]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe: reset, modes, streaming, backpressure, flush, parameter sweep.
module tb_shift_unit_pipe;

    logic        Clk = 1'b0;
    logic        Reset, Flush, InValid, OutReady;
    logic [31:0] InData;
    logic [4:0]  InShamt;
    logic [1:0]  InMode;
    logic [4:0]  InTag;
    logic        InReady, OutValid, OutZero;
    logic [31:0] OutData;
    logic [4:0]  OutTag;

    logic        sw_rdy [3];
    logic        sw_vld [3];
    logic        sw_zero[3];
    logic [31:0] sw_data[3];
    logic [4:0]  sw_tag [3];

    logic [7:0]  d8;
    logic [2:0]  sh8;
    logic        w8_rdy, w8_vld, w8_zero;
    logic [7:0]  w8_data;
    logic [4:0]  w8_tag;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    shift_unit_pipe dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .InData(InData), .InShamt(InShamt), .InMode(InMode), .InTag(InTag),
        .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData), .OutTag(OutTag),
        .OutZero(OutZero)
    );

    shift_unit_pipe #(.STAGES(1)) u_s1 (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(sw_rdy[0]),
        .InData(InData), .InShamt(InShamt), .InMode(InMode), .InTag(InTag),
        .OutValid(sw_vld[0]), .OutReady(1'b1), .OutData(sw_data[0]), .OutTag(sw_tag[0]),
        .OutZero(sw_zero[0])
    );

    shift_unit_pipe #(.STAGES(3)) u_s3 (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(sw_rdy[1]),
        .InData(InData), .InShamt(InShamt), .InMode(InMode), .InTag(InTag),
        .OutValid(sw_vld[1]), .OutReady(1'b1), .OutData(sw_data[1]), .OutTag(sw_tag[1]),
        .OutZero(sw_zero[1])
    );

    shift_unit_pipe #(.STAGES(5)) u_s5 (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(sw_rdy[2]),
        .InData(InData), .InShamt(InShamt), .InMode(InMode), .InTag(InTag),
        .OutValid(sw_vld[2]), .OutReady(1'b1), .OutData(sw_data[2]), .OutTag(sw_tag[2]),
        .OutZero(sw_zero[2])
    );

    shift_unit_pipe #(.WIDTH(8), .STAGES(3)) u_w8 (
        .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(w8_rdy),
        .InData(d8), .InShamt(sh8), .InMode(InMode), .InTag(InTag),
        .OutValid(w8_vld), .OutReady(1'b1), .OutData(w8_data), .OutTag(w8_tag),
        .OutZero(w8_zero)
    );

    function automatic logic [31:0] model32(input logic [31:0] d, input int sh, input logic [1:0] m);
        logic [63:0] dd;
        case (m)
            2'b00:   return d << sh;
            2'b01:   return d >> sh;
            2'b10:   return 32'($signed(d) >>> sh);
            default: begin
                dd = {d, d} >> sh;
                return dd[31:0];
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Flush = 1'b0; InValid = 1'b1; OutReady = 1'b1;
        InData = 32'h1234_5678; InShamt = 5'd3; InMode = 2'b01; InTag = 5'd9;
        d8 = 8'h00; sh8 = 3'd0;
        repeat (3) begin
            tick();
            checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL reset_inready: got %b want 0", InReady); end
            checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b want 0", OutValid); end
        end
        Reset = 1'b0; InValid = 1'b0;
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL post_reset_inready: got %b want 1", InReady); end
        checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL post_reset_outvalid: got %b want 0", OutValid); end
        checks++; if (OutData !== 32'h0) begin errors++; $display("FAIL post_reset_outdata: got %h want 0", OutData); end
        checks++; if (OutTag !== 5'h0) begin errors++; $display("FAIL post_reset_outtag: got %h want 0", OutTag); end
        checks++; if (OutZero !== 1'b1) begin errors++; $display("FAIL post_reset_outzero: got %b want 1", OutZero); end
    endtask

    task automatic test_modes();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h0000_0F10;
        exp_tab[1] = 32'h0800_000F;
        exp_tab[2] = 32'hF800_000F;
        exp_tab[3] = 32'h1800_000F;
        OutReady = 1'b1;
        for (int m = 0; m < 4; m++) begin
            tick();
            InValid = 1'b1; InData = 32'h8000_00F1; InShamt = 5'd4; InMode = 2'(m); InTag = 5'(m + 3);
            #1;
            checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL mode%0d_inready: got %b want 1", m, InReady); end
            tick();
            InValid = 1'b0;
            checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL mode%0d_early: got %b want 0", m, OutValid); end
            tick();
            checks++; if (OutValid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b want 1", m, OutValid); end
            checks++; if (OutData !== exp_tab[m]) begin errors++; $display("FAIL mode%0d_data: got %h want %h", m, OutData, exp_tab[m]); end
            checks++; if (OutTag !== 5'(m + 3)) begin errors++; $display("FAIL mode%0d_tag: got %h want %h", m, OutTag, 5'(m + 3)); end
            checks++; if (OutZero !== 1'b0) begin errors++; $display("FAIL mode%0d_zero: got %b want 0", m, OutZero); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd [100];
        logic [4:0]  rs [100];
        logic [1:0]  rm [100];
        logic [31:0] exp_q [$];
        logic [4:0]  tag_q [$];
        int idx = 0, recv = 0, last_it = 0;
        for (int i = 0; i < 100; i++) begin
            rd[i] = $urandom;
            rm[i] = 2'($urandom_range(0, 3));
            rs[i] = (i % 10 == 0) ? 5'd0 : (i % 10 == 5) ? 5'd31 : 5'($urandom_range(0, 31));
        end
        rd[7] = 32'h8000_0000; rs[7] = 5'd0;
        for (int it = 1; it <= 300 && recv < 100; it++) begin
            tick();
            OutReady = 1'b1;
            InValid  = (idx < 100);
            if (idx < 100) begin
                InData = rd[idx]; InShamt = rs[idx]; InMode = rm[idx]; InTag = 5'(idx);
            end
            #1;
            if (OutValid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got %h want none", OutData);
                end else begin
                    if (OutData !== exp_q[0] || OutTag !== tag_q[0] || OutZero !== (exp_q[0] == 32'h0)) begin
                        errors++;
                        $display("FAIL b2b_data%0d: got %h/%h want %h/%h", recv, OutData, OutTag, exp_q[0], tag_q[0]);
                    end
                    void'(exp_q.pop_front()); void'(tag_q.pop_front());
                end
                recv++;
                last_it = it;
            end
            if (idx < 100) begin
                checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL b2b_bubble%0d: got %b want 1", idx, InReady); end
            end
            if (InValid && InReady) begin
                exp_q.push_back(model32(rd[idx], int'(rs[idx]), rm[idx]));
                tag_q.push_back(5'(idx));
                idx++;
            end
        end
        InValid = 1'b0;
        checks++; if (recv !== 100) begin errors++; $display("FAIL b2b_count: got %0d want 100", recv); end
        checks++; if (last_it !== 102) begin errors++; $display("FAIL b2b_cycles: got %0d want 102", last_it); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd [60];
        logic [4:0]  rs [60];
        logic [1:0]  rm [60];
        logic [31:0] exp_q [$];
        logic [4:0]  tag_q [$];
        logic [31:0] prev_d = '0;
        logic [4:0]  prev_t = '0;
        logic        prev_stall = 1'b0;
        int idx = 0, recv = 0;
        for (int i = 0; i < 60; i++) begin
            rd[i] = $urandom;
            rs[i] = 5'($urandom_range(0, 31));
            rm[i] = 2'($urandom_range(0, 3));
        end
        for (int it = 0; it < 1000 && recv < 60; it++) begin
            tick();
            OutReady = 1'($urandom_range(0, 1));
            InValid  = (idx < 60) && ($urandom_range(0, 3) != 0);
            if (idx < 60) begin
                InData = rd[idx]; InShamt = rs[idx]; InMode = rm[idx]; InTag = 5'(idx);
            end
            #1;
            if (prev_stall) begin
                checks++;
                if (OutValid !== 1'b1 || OutData !== prev_d || OutTag !== prev_t) begin
                    errors++; $display("FAIL bp_stable: got %b/%h/%h want 1/%h/%h", OutValid, OutData, OutTag, prev_d, prev_t);
                end
            end
            checks++;
            if (InReady !== !(exp_q.size() == 2 && !OutReady)) begin
                errors++; $display("FAIL bp_inready: got %b want %b (occupancy %0d)", InReady, !(exp_q.size() == 2 && !OutReady), exp_q.size());
            end
            if (OutValid && OutReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got %h want none", OutData);
                end else begin
                    if (OutData !== exp_q[0] || OutTag !== tag_q[0]) begin
                        errors++; $display("FAIL bp_data%0d: got %h/%h want %h/%h", recv, OutData, OutTag, exp_q[0], tag_q[0]);
                    end
                    void'(exp_q.pop_front()); void'(tag_q.pop_front());
                end
                recv++;
            end
            if (InValid && InReady) begin
                exp_q.push_back(model32(rd[idx], int'(rs[idx]), rm[idx]));
                tag_q.push_back(5'(idx));
                idx++;
            end
            prev_stall = OutValid && !OutReady;
            prev_d = OutData;
            prev_t = OutTag;
        end
        InValid = 1'b0; OutReady = 1'b1;
        checks++; if (recv !== 60) begin errors++; $display("FAIL bp_count: got %0d want 60", recv); end
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_leftover: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        tick();
        OutReady = 1'b0; Flush = 1'b0;
        InValid = 1'b1; InData = 32'h0000_00F0; InShamt = 5'd4; InMode = 2'b01; InTag = 5'd1;
        tick();
        InData = 32'h0000_0001; InShamt = 5'd1; InMode = 2'b00; InTag = 5'd2;
        #1;
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL flush_load_b: got %b want 1", InReady); end
        tick();
        Flush = 1'b1; InData = 32'hFFFF_FFFF; InTag = 5'd3;
        #1;
        checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL flush_inready: got %b want 0", InReady); end
        checks++; if (OutValid !== 1'b1 || OutData !== 32'h0000_000F) begin
            errors++; $display("FAIL flush_held: got %b/%h want 1/0000000f", OutValid, OutData);
        end
        tick();
        Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (OutValid !== 1'b0) begin errors++; $display("FAIL flush_quiet%0d: got %b want 0", i, OutValid); end
            tick();
        end
        InValid = 1'b1; InData = 32'h8000_0001; InShamt = 5'd1; InMode = 2'b11; InTag = 5'd7;
        tick();
        InValid = 1'b0;
        tick();
        checks++; if (OutValid !== 1'b1 || OutData !== 32'hC000_0000 || OutTag !== 5'd7) begin
            errors++; $display("FAIL flush_next: got %b/%h/%h want 1/c0000000/07", OutValid, OutData, OutTag);
        end
    endtask

    task automatic test_reset_mid_stall();
        tick();
        OutReady = 1'b0;
        InValid = 1'b1; InData = 32'h0000_0100; InShamt = 5'd8; InMode = 2'b01; InTag = 5'd4;
        tick();
        InValid = 1'b0;
        tick();
        tick();
        checks++; if (OutValid !== 1'b1 || OutData !== 32'h0000_0001) begin
            errors++; $display("FAIL rst_stall_held: got %b/%h want 1/00000001", OutValid, OutData);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0; OutReady = 1'b1;
        checks++; if (OutValid !== 1'b0 || OutData !== 32'h0 || OutZero !== 1'b1) begin
            errors++; $display("FAIL rst_stall_drop: got %b/%h/%b want 0/0/1", OutValid, OutData, OutZero);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] v32 [4];
        logic [4:0]  s32 [4];
        logic [1:0]  vm  [4];
        logic [7:0]  v8  [4];
        logic [2:0]  s8  [4];
        logic [7:0]  e8  [4];
        int          stg [3];
        int          lat [3];
        logic [31:0] got [3];
        logic [4:0]  gtg [3];
        int          lat8;
        logic [7:0]  got8;
        v32[0] = 32'h8000_00F1; s32[0] = 5'd4;  vm[0] = 2'b10; v8[0] = 8'h80; s8[0] = 3'd7; e8[0] = 8'hFF;
        v32[1] = 32'h1234_5678; s32[1] = 5'd31; vm[1] = 2'b11; v8[1] = 8'h96; s8[1] = 3'd3; e8[1] = 8'hD2;
        v32[2] = 32'hDEAD_BEEF; s32[2] = 5'd13; vm[2] = 2'b00; v8[2] = 8'h5A; s8[2] = 3'd1; e8[2] = 8'hB4;
        v32[3] = 32'hCAFE_F00D; s32[3] = 5'd0;  vm[3] = 2'b01; v8[3] = 8'hF0; s8[3] = 3'd4; e8[3] = 8'h0F;
        stg[0] = 1; stg[1] = 3; stg[2] = 5;
        InValid = 1'b0; OutReady = 1'b1;
        repeat (8) tick();
        for (int v = 0; v < 4; v++) begin
            tick();
            InValid = 1'b1; InData = v32[v]; InShamt = s32[v]; InMode = vm[v]; InTag = 5'(v + 20);
            d8 = v8[v]; sh8 = s8[v];
            for (int k = 0; k < 3; k++) begin lat[k] = -1; got[k] = '0; gtg[k] = '0; end
            lat8 = -1; got8 = '0;
            for (int i = 1; i <= 8; i++) begin
                tick();
                InValid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (sw_vld[k] && lat[k] < 0) begin lat[k] = i; got[k] = sw_data[k]; gtg[k] = sw_tag[k]; end
                end
                if (w8_vld && lat8 < 0) begin lat8 = i; got8 = w8_data; end
            end
            for (int k = 0; k < 3; k++) begin
                checks++; if (lat[k] !== stg[k]) begin errors++; $display("FAIL sweep_s%0d_lat%0d: got %0d want %0d", stg[k], v, lat[k], stg[k]); end
                checks++;
                if (got[k] !== model32(v32[v], int'(s32[v]), vm[v]) || gtg[k] !== 5'(v + 20)) begin
                    errors++; $display("FAIL sweep_s%0d_data%0d: got %h/%h want %h/%h", stg[k], v, got[k], gtg[k], model32(v32[v], int'(s32[v]), vm[v]), 5'(v + 20));
                end
            end
            checks++; if (lat8 !== 3) begin errors++; $display("FAIL sweep_w8_lat%0d: got %0d want 3", v, lat8); end
            checks++; if (got8 !== e8[v]) begin errors++; $display("FAIL sweep_w8_data%0d: got %h want %h", v, got8, e8[v]); end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
